// File: rtl/video_timing_pkg.sv
// Shared constants and phase type for the 720p raster timing generator.
package video_timing_pkg;

  localparam int unsigned CNT_W = 12;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned H_FP_720P     = 110;
  localparam int unsigned H_SYNC_720P   = 40;
  localparam int unsigned H_BP_720P     = 220;
  localparam int unsigned H_TOTAL_720P  = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;

  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned V_FP_720P     = 5;
  localparam int unsigned V_SYNC_720P   = 5;
  localparam int unsigned V_BP_720P     = 20;
  localparam int unsigned V_TOTAL_720P  = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  // Both axes walk the same four phases in the same order.
  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e cur, input logic at_end);
    phase_e nxt;
    nxt = cur;
    if (at_end) begin
      unique case (cur)
        PH_ACT:  nxt = PH_FP;
        PH_FP:   nxt = PH_SYNC;
        PH_SYNC: nxt = PH_BP;
        PH_BP:   nxt = PH_ACT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth 3-bit register chain that aligns VDE/HSYNC/VSYNC with pixel data latency.
module sig_delay #(
  parameter int         DEPTH   = 1,
  parameter logic [2:0] RST_VAL = 3'b011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] stage [DEPTH];

  // NOTE: every stage is reset, not just the output, so no stale sync/DE pulse escapes after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, phase FSMs, polarity-adjusted delayed syncs and frame tick.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
  parameter int unsigned H_FP     = H_FP_720P,
  parameter int unsigned H_SYNC   = H_SYNC_720P,
  parameter int unsigned H_BP     = H_BP_720P,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
  parameter int unsigned V_FP     = V_FP_720P,
  parameter int unsigned V_SYNC   = V_SYNC_720P,
  parameter int unsigned V_BP     = V_BP_720P,
  parameter bit          SYNC_POL = 1'b1,
  parameter int          PIPE_DLY = 1  // legal range 1..8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] Set_X,
  output logic [CNT_W-1:0] Set_Y,
  output logic             RGB_VDE,
  output logic             RGB_HSYNC,
  output logic             RGB_VSYNC,
  output logic             frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter value of each phase; the phase changes on the following clock.
  localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_FP_LAST   = CNT_W'(H_ACTIVE + H_FP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_FP_LAST   = CNT_W'(V_ACTIVE + V_FP - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_TICK_LINE = CNT_W'(V_ACTIVE);

  localparam logic [2:0] DLY_RST_VAL = {1'b0, ~SYNC_POL, ~SYNC_POL};

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  phase_e           h_state, h_next;
  phase_e           v_state, v_next;
  logic             h_end;
  logic             v_end;
  logic             de_raw;
  logic             hs_raw;
  logic             vs_raw;
  logic [2:0]       dly_d;
  logic [2:0]       dly_q;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_state <= PH_ACT;
      v_state <= PH_ACT;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // NOTE: defaults first keep this block purely combinational (no latches) whatever the case path.
  always_comb begin
    h_end = 1'b0;
    v_end = 1'b0;
    unique case (h_state)
      PH_ACT:  h_end = (h_cnt == H_ACT_LAST);
      PH_FP:   h_end = (h_cnt == H_FP_LAST);
      PH_SYNC: h_end = (h_cnt == H_SYNC_LAST);
      PH_BP:   h_end = h_wrap;
    endcase
    // Vertical phases only advance at the end of a line.
    unique case (v_state)
      PH_ACT:  v_end = h_wrap && (v_cnt == V_ACT_LAST);
      PH_FP:   v_end = h_wrap && (v_cnt == V_FP_LAST);
      PH_SYNC: v_end = h_wrap && (v_cnt == V_SYNC_LAST);
      PH_BP:   v_end = h_wrap && v_wrap;
    endcase
    h_next = next_phase(h_state, h_end);
    v_next = next_phase(v_state, v_end);
  end

  assign de_raw = (h_state == PH_ACT) && (v_state == PH_ACT);
  assign hs_raw = (h_state == PH_SYNC);
  assign vs_raw = (v_state == PH_SYNC);

  assign dly_d = {de_raw,
                  hs_raw ? SYNC_POL : ~SYNC_POL,
                  vs_raw ? SYNC_POL : ~SYNC_POL};

  sig_delay #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (DLY_RST_VAL)
  ) u_sig_delay (
    .clk (clk),
    .rst (rst),
    .d   (dly_d),
    .q   (dly_q)
  );

  assign Set_X = h_cnt;
  assign Set_Y = v_cnt;
  assign {RGB_VDE, RGB_HSYNC, RGB_VSYNC} = dly_q;

  // Start of vertical blanking, aligned with the counters rather than the delayed outputs.
  assign frame_tick = (h_cnt == '0) && (v_cnt == V_TICK_LINE);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 720p instance for line timing, a shrunken raster for frame/wrap/reset checks.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  // Shrunken raster: 28 clocks per line, 17 lines per frame, 476 clocks per frame.
  localparam int unsigned SH_ACT = 16, SH_FP = 4, SH_SYNC = 3, SH_BP = 5;
  localparam int unsigned SV_ACT = 10, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, rst_b;
  logic [CNT_W-1:0] x_a, y_a, x_b, y_b;
  logic             vde_a, hs_a, vs_a, tick_a;
  logic             vde_b, hs_b, vs_b, tick_b;

  int total = 0;
  int bad   = 0;

  video_timing_gen dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .Set_X      (x_a),
    .Set_Y      (y_a),
    .RGB_VDE    (vde_a),
    .RGB_HSYNC  (hs_a),
    .RGB_VSYNC  (vs_a),
    .frame_tick (tick_a)
  );

  video_timing_gen #(
    .H_ACTIVE (SH_ACT), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
    .V_ACTIVE (SV_ACT), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP),
    .SYNC_POL (1'b0),
    .PIPE_DLY (3)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .Set_X      (x_b),
    .Set_Y      (y_b),
    .RGB_VDE    (vde_b),
    .RGB_HSYNC  (hs_b),
    .RGB_VSYNC  (vs_b),
    .frame_tick (tick_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int vde_cnt, hs_cnt, vs_cnt, hs_rise_x, vde_fall_x;
    int vde_rise_c, hs_low_c, vs_low_c, tick_cnt, tick1_c, tick2_c;
    bit seen_vde, found;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) step();

    // ---- Default 720p instance: reset release and line 0 ----
    rst_a = 1'b0;
    check("a_rst_x",    int'(x_a),    0);
    check("a_rst_y",    int'(y_a),    0);
    check("a_rst_vde",  int'(vde_a),  0);
    check("a_rst_hs",   int'(hs_a),   0);
    check("a_rst_vs",   int'(vs_a),   0);
    check("a_rst_tick", int'(tick_a), 0);

    vde_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_rise_x = -1; vde_fall_x = -1; seen_vde = 1'b0;
    for (int c = 1; c <= 1650; c++) begin
      step();
      if (c == 1) begin
        check("a_c1_x",   int'(x_a),   1);
        check("a_c1_vde", int'(vde_a), 1);
      end
      if (vde_a) begin
        vde_cnt++;
        seen_vde = 1'b1;
      end else if (seen_vde && vde_fall_x < 0) begin
        vde_fall_x = int'(x_a);
      end
      if (hs_a) begin
        if (hs_rise_x < 0) hs_rise_x = int'(x_a);
        hs_cnt++;
      end
      if (vs_a || tick_a) vs_cnt++;
    end
    check("a_vde_width",   vde_cnt,    1280);
    check("a_vde_fall_x",  vde_fall_x, 1281);
    check("a_hs_width",    hs_cnt,     40);
    check("a_hs_rise_x",   hs_rise_x,  1391);
    check("a_vs_tick_l0",  vs_cnt,     0);
    check("a_line_len_x",  int'(x_a),  0);
    check("a_line_len_y",  int'(y_a),  1);
    rst_a = 1'b1;

    // ---- Shrunken instance (PIPE_DLY=3, SYNC_POL=0): reset, frame, wrap ----
    rst_b = 1'b0;
    check("b_rst_x",    int'(x_b),    0);
    check("b_rst_y",    int'(y_b),    0);
    check("b_rst_vde",  int'(vde_b),  0);
    check("b_rst_hs",   int'(hs_b),   1);
    check("b_rst_vs",   int'(vs_b),   1);
    check("b_rst_tick", int'(tick_b), 0);

    vde_cnt = 0; hs_cnt = 0; vs_cnt = 0; tick_cnt = 0;
    vde_rise_c = -1; hs_low_c = -1; vs_low_c = -1; tick1_c = -1; tick2_c = -1;
    for (int c = 1; c <= 800; c++) begin
      step();
      if (vde_b && vde_rise_c < 0) vde_rise_c = c;
      if (!hs_b && hs_low_c < 0)   hs_low_c = c;
      if (!vs_b && vs_low_c < 0)   vs_low_c = c;
      // Delayed outputs at cycles 3..478 describe counter cycles 0..475, one whole frame.
      if (c >= 3 && c <= 478) begin
        if (vde_b) vde_cnt++;
        if (!hs_b) hs_cnt++;
        if (!vs_b) vs_cnt++;
      end
      if (tick_b) begin
        tick_cnt++;
        if (tick1_c < 0) tick1_c = c;
        else if (tick2_c < 0) tick2_c = c;
      end
      if (c == 475) begin
        check("b_prewrap_x", int'(x_b), 27);
        check("b_prewrap_y", int'(y_b), 16);
      end
      if (c == 476) begin
        check("b_wrap_x",    int'(x_b),    0);
        check("b_wrap_y",    int'(y_b),    0);
        check("b_wrap_tick", int'(tick_b), 0);
      end
    end
    check("b_vde_rise_cycle", vde_rise_c, 3);
    check("b_hs_low_cycle",   hs_low_c,   23);
    check("b_vs_low_cycle",   vs_low_c,   339);
    check("b_vde_per_frame",  vde_cnt,    160);
    check("b_hs_low_frame",   hs_cnt,     51);
    check("b_vs_low_frame",   vs_cnt,     56);
    check("b_tick_first",     tick1_c,    280);
    check("b_tick_second",    tick2_c,    756);
    check("b_tick_count",     tick_cnt,   2);

    // ---- Mid-frame reset on an active line ----
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      if (int'(x_b) == 5 && int'(y_b) == 8) found = 1'b1;
      else step();
    end
    check("b_mid_found", int'(found), 1);
    check("b_mid_vde_active", int'(vde_b), 1);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check("b_mid_x",   int'(x_b),   0);
    check("b_mid_y",   int'(y_b),   0);
    check("b_mid_vde", int'(vde_b), 0);
    check("b_mid_hs",  int'(hs_b),  1);
    check("b_mid_vs",  int'(vs_b),  1);
    vde_rise_c = -1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (vde_b && vde_rise_c < 0) vde_rise_c = c;
    end
    check("b_mid_vde_rise", vde_rise_c, 3);
    check("b_mid_x5",       int'(x_b),  5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
